// File: rtl/riscv_mem_arb.sv
// Single-port RAM arbiter for the instruction and data ports, one access per cycle.
// Define RISCV_MEM_ARB_RR_EN for round-robin priority; default is data-first priority.
module riscv_mem_arb #(
    parameter int DATA_WIDTH  = 64,
    parameter int IDATA_WIDTH = DATA_WIDTH / 2,
    parameter int ADDR_WIDTH  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sft_rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [IDATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-4:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INSTR,
        OWN_DATA
    } owner_e;

    owner_e owner_q;
    logic   half_q;
    logic   pick_i;

`ifdef RISCV_MEM_ARB_RR_EN
    logic last_i_q;

    // On a tie, the port that did not win last time goes first.
    always_comb begin
        pick_i = i_req & (~d_req | ~last_i_q);
    end
`else
    always_comb begin
        pick_i = i_req & ~d_req;
    end
`endif

    // Grants are masked while rst_n is low so the RAM stays idle in reset.
    assign i_gnt = rst_n & pick_i;
    assign d_gnt = rst_n & d_req & ~pick_i;

    assign ram_cs      = i_gnt | d_gnt;
    assign ram_we      = d_gnt & d_we;
    assign ram_addr    = i_gnt ? i_addr[ADDR_WIDTH-1:3] : d_addr[ADDR_WIDTH-1:3];
    assign ram_wr_data = d_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= OWN_NONE;
            half_q   <= 1'b0;
`ifdef RISCV_MEM_ARB_RR_EN
            last_i_q <= 1'b1;
`endif
        end else if (sft_rst) begin
            owner_q  <= OWN_NONE;
            half_q   <= 1'b0;
`ifdef RISCV_MEM_ARB_RR_EN
            last_i_q <= 1'b1;
`endif
        end else begin
            unique case (1'b1)
                i_gnt: begin
                    owner_q <= OWN_INSTR;
                    half_q  <= i_addr[2];
                end
                (d_gnt & ~d_we): begin
                    owner_q <= OWN_DATA;
                end
                default: begin
                    owner_q <= OWN_NONE;
                end
            endcase
`ifdef RISCV_MEM_ARB_RR_EN
            if (ram_cs) begin
                last_i_q <= i_gnt;
            end
`endif
        end
    end

    assign i_rvalid = (owner_q == OWN_INSTR);
    assign d_rvalid = (owner_q == OWN_DATA);
    assign d_rdata  = ram_rd_data;
    assign i_rdata  = half_q ? ram_rd_data[DATA_WIDTH-1:IDATA_WIDTH]
                             : ram_rd_data[IDATA_WIDTH-1:0];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[2:0]};

endmodule

// File: tb/tb_riscv_mem_arb.sv
// Directed bench for riscv_mem_arb with a one-cycle-latency RAM model.
// Tie-break expectations follow RISCV_MEM_ARB_RR_EN when it is defined.
module tb_riscv_mem_arb;

    logic        clk;
    logic        rst_n;
    logic        sft_rst;
    logic        i_req;
    logic [13:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [13:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        ram_cs;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [63:0] ram_wr_data;
    logic [63:0] ram_rd_data;

    logic [63:0] mem [0:2047];

    int checks;
    int failures;

    riscv_mem_arb dut (
        .clk(clk),
        .rst_n(rst_n),
        .sft_rst(sft_rst),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_gnt(i_gnt),
        .i_rvalid(i_rvalid),
        .i_rdata(i_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_gnt(d_gnt),
        .d_rvalid(d_rvalid),
        .d_rdata(d_rdata),
        .ram_cs(ram_cs),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_wr_data(ram_wr_data),
        .ram_rd_data(ram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_wr_data;
            else        ram_rd_data   <= mem[ram_addr];
        end
    end

    task automatic idle_inputs();
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        sft_rst = 1'b0;
        idle_inputs();
        ram_rd_data = '0;
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        mem[0] = 64'hDEADBEEF_01234567;
        i_req = 1'b1;
        d_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({ram_cs, ram_we, i_gnt, d_gnt} !== 4'b0000) begin
            $display("FAIL reset_gnt got=%b want=0000",
                     {ram_cs, ram_we, i_gnt, d_gnt});
            failures++;
        end
        checks++;
        if ({i_rvalid, d_rvalid} !== 2'b00) begin
            $display("FAIL reset_rvalid got=%b want=00", {i_rvalid, d_rvalid});
            failures++;
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({ram_cs, ram_we, i_rvalid, d_rvalid} !== 4'b0000) begin
            $display("FAIL post_reset got=%b want=0000",
                     {ram_cs, ram_we, i_rvalid, d_rvalid});
            failures++;
        end
    endtask

    task automatic test_instr_read();
        @(negedge clk);
        i_req  = 1'b1;
        i_addr = 14'h0004;
        #1;
        checks++;
        if ({i_gnt, d_gnt, ram_cs, ram_we} !== 4'b1010 || ram_addr !== 11'd0) begin
            $display("FAIL ird_gnt got=%b addr=%0d want=1010 addr=0",
                     {i_gnt, d_gnt, ram_cs, ram_we}, ram_addr);
            failures++;
        end
        @(negedge clk);
        i_addr = 14'h0000;
        #1;
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'hDEADBEEF) begin
            $display("FAIL ird_hi got=%b %h want=1 deadbeef", i_rvalid, i_rdata);
            failures++;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h01234567) begin
            $display("FAIL ird_lo got=%b %h want=1 01234567", i_rvalid, i_rdata);
            failures++;
        end
        @(negedge clk);
        #1;
        checks++;
        if ({i_rvalid, d_rvalid, ram_cs} !== 3'b000) begin
            $display("FAIL ird_idle got=%b want=000", {i_rvalid, d_rvalid, ram_cs});
            failures++;
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 14'h0010;
        d_wdata = 64'h1122334455667788;
        #1;
        checks++;
        if ({d_gnt, i_gnt, ram_cs, ram_we} !== 4'b1011 || ram_addr !== 11'd2
            || ram_wr_data !== 64'h1122334455667788) begin
            $display("FAIL wr_gnt got=%b addr=%0d data=%h want=1011 addr=2",
                     {d_gnt, i_gnt, ram_cs, ram_we}, ram_addr, ram_wr_data);
            failures++;
        end
        @(negedge clk);
        d_we = 1'b0;
        #1;
        checks++;
        if ({d_rvalid, d_gnt, ram_we} !== 3'b010 || ram_addr !== 11'd2) begin
            $display("FAIL wr_then_rd got=%b addr=%0d want=010 addr=2",
                     {d_rvalid, d_gnt, ram_we}, ram_addr);
            failures++;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0
            || d_rdata !== 64'h1122334455667788) begin
            $display("FAIL rd_back got=%b%b %h want=10 1122334455667788",
                     d_rvalid, i_rvalid, d_rdata);
            failures++;
        end
    endtask

    task automatic test_priority();
        logic [3:0] want_i;
`ifdef RISCV_MEM_ARB_RR_EN
        want_i = 4'b1010;
`else
        want_i = 4'b0000;
`endif
        @(negedge clk);
        sft_rst = 1'b1;
        @(negedge clk);
        sft_rst = 1'b0;
        i_req   = 1'b1;
        i_addr  = 14'h0004;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 14'h0010;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) idle_inputs();
            #1;
            if (k < 4) begin
                checks++;
                if (i_gnt !== want_i[k] || d_gnt !== !want_i[k]) begin
                    $display("FAIL prio_c%0d got=i%b d%b want=i%b d%b",
                             k, i_gnt, d_gnt, want_i[k], !want_i[k]);
                    failures++;
                end
            end
            if (k > 0) begin
                checks++;
                if (i_rvalid !== want_i[k-1] || d_rvalid !== !want_i[k-1]
                    || (want_i[k-1] && i_rdata !== 32'hDEADBEEF)
                    || (!want_i[k-1] && d_rdata !== 64'h1122334455667788)) begin
                    $display("FAIL prio_rv%0d got=i%b d%b %h %h",
                             k, i_rvalid, d_rvalid, i_rdata, d_rdata);
                    failures++;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sft_rst();
        @(negedge clk);
        i_req   = 1'b1;
        i_addr  = 14'h0004;
        sft_rst = 1'b1;
        #1;
        checks++;
        if ({i_gnt, ram_cs} !== 2'b11) begin
            $display("FAIL srst_gnt got=%b want=11", {i_gnt, ram_cs});
            failures++;
        end
        @(negedge clk);
        sft_rst = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if ({i_rvalid, d_rvalid} !== 2'b00) begin
            $display("FAIL srst_rvalid got=%b want=00", {i_rvalid, d_rvalid});
            failures++;
        end
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        i_req  = 1'b1;
        i_addr = 14'h0004;
        @(negedge clk);
        i_req  = 1'b0;
        d_req  = 1'b1;
        d_addr = 14'h0010;
        #1;
        checks++;
        if ({i_rvalid, d_gnt} !== 2'b11) begin
            $display("FAIL mid_pre got=%b want=11", {i_rvalid, d_gnt});
            failures++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({i_rvalid, d_rvalid, ram_cs, ram_we, d_gnt} !== 5'b00000) begin
            $display("FAIL mid_rst got=%b want=00000",
                     {i_rvalid, d_rvalid, ram_cs, ram_we, d_gnt});
            failures++;
        end
        @(negedge clk);
        #1;
        checks++;
        if ({i_rvalid, d_rvalid, ram_cs} !== 3'b000) begin
            $display("FAIL mid_hold got=%b want=000", {i_rvalid, d_rvalid, ram_cs});
            failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        i_req = 1'b1;
        d_req = 1'b1;
        #1;
        checks++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            $display("FAIL mid_first got=%b want=01", {i_gnt, d_gnt});
            failures++;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if ({i_rvalid, d_rvalid} !== 2'b01 || d_rdata !== 64'h1122334455667788) begin
            $display("FAIL mid_rv got=%b %h want=01 1122334455667788",
                     {i_rvalid, d_rvalid}, d_rdata);
            failures++;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_instr_read();
        test_write_read();
        test_priority();
        test_sft_rst();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arb.md
RISCV_MEM_ARB -- requirements
Module: riscv_mem_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 64: RAM and data-port word width in bits.
REQ-002 Parameter IDATA_WIDTH, default 32: instruction-port read width in bits; fixed at DATA_WIDTH/2.
REQ-003 Parameter ADDR_WIDTH, default 14: byte-address width of both requester ports.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 sft_rst  input  1  synchronous reset, active-high.
REQ-007 i_req  input  1  instruction fetch request (read only).
REQ-008 i_addr  input  ADDR_WIDTH  instruction byte address; bits [1:0] ignored.
REQ-009 i_gnt  output  1  instruction request accepted this cycle.
REQ-010 i_rvalid  output  1  instruction read data valid.
REQ-011 i_rdata  output  IDATA_WIDTH  instruction read data.
REQ-012 d_req  input  1  data access request.
REQ-013 d_we  input  1  data write enable; qualified by d_req.
REQ-014 d_addr  input  ADDR_WIDTH  data byte address; bits [2:0] ignored.
REQ-015 d_wdata  input  DATA_WIDTH  data write data.
REQ-016 d_gnt  output  1  data request accepted this cycle.
REQ-017 d_rvalid  output  1  data read data valid; never asserted for writes.
REQ-018 d_rdata  output  DATA_WIDTH  data read data.
REQ-019 ram_cs, ram_we  output  1 each  single-port RAM chip select and write enable.
REQ-020 ram_addr  output  ADDR_WIDTH-3  RAM word address.
REQ-021 ram_wr_data  output  DATA_WIDTH  RAM write data.
REQ-022 ram_rd_data  input  DATA_WIDTH  RAM read data, valid one cycle after a read access.

Function
REQ-023 The block shall perform at most one RAM access per cycle; i_gnt and d_gnt shall never be high together.
REQ-024 Grant shall be combinational from the same-cycle requests: a lone requester is granted in the cycle its req is high.
REQ-025 On grant, ram_cs=1, ram_addr=granted addr[ADDR_WIDTH-1:3], ram_we=d_we for a data grant, and ram_we=0 for an instruction grant.
REQ-026 When no grant is issued, ram_cs and ram_we shall be 0; ram_addr and ram_wr_data are don't-care.
REQ-027 A registered response owner (NONE/INSTR/DATA) and a registered half-select (i_addr[2]) shall be captured on each read grant; a write grant or idle cycle captures NONE.
REQ-028 A read grant in cycle N shall produce the matching rvalid in cycle N+1, with rdata taken from ram_rd_data.
REQ-029 i_rdata shall be ram_rd_data[63:32] when the captured half-select is 1, else ram_rd_data[31:0].
REQ-030 Back-to-back grants shall be supported: a new grant may issue in the same cycle as the previous rvalid (throughput 1 access/cycle).
REQ-031 Requesters shall hold req and addr stable until granted; the block keeps no request queue.
REQ-032 A write shall be complete when d_gnt is high; a read of the same address granted in the next cycle shall return the new data.

Reset
REQ-033 On rst_n low or sft_rst high: response owner=NONE, half-select=0, round-robin pointer=INSTR-last (data favoured next).
REQ-034 During and immediately after reset, i_rvalid, d_rvalid, ram_cs and ram_we shall be 0; rvalid for a read granted in the cycle sft_rst is asserted shall be suppressed.
REQ-035 i_rdata and d_rdata are don't-care while the corresponding rvalid is 0.

Configuration
REQ-036 Macro RISCV_MEM_ARB_RR_EN: when defined, a registered last-grant pointer alternates priority on simultaneous requests, so the requester not granted last wins; the pointer updates only on a grant.
REQ-037 Without RISCV_MEM_ARB_RR_EN, simultaneous requests always grant the data port (fixed priority), and no pointer register exists.

Verification
REQ-038 i_req=1, i_addr=0x0004, RAM word 0=0xDEADBEEF_01234567 -> i_gnt cycle N, ram_addr=0; i_rvalid cycle N+1, i_rdata=0xDEADBEEF.
REQ-039 d_req=1, d_we=1, d_addr=0x0010, d_wdata=0x1122334455667788, then d_we=0 read of same address -> ram_we=1 ram_addr=2; next cycle d_rvalid=0; the following cycle d_rvalid=1, d_rdata=0x1122334455667788.
REQ-040 i_req and d_req held high for 4 cycles, fixed priority -> d_gnt on all 4 cycles, i_gnt=0; with RISCV_MEM_ARB_RR_EN -> grant sequence D,I,D,I.
REQ-041 Read grant at cycle N with sft_rst=1 at cycle N -> no rvalid at N+1; owner=NONE.
REQ-042 rst_n pulsed low mid-stream with alternating reads pending -> all rvalid and ram_cs drop immediately; the first grant after release follows REQ-033 priority.
